// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
//   Bus-side interface of the UART receive stage. It groups the FIFO pop and
//   status-clear strobes with the FIFO head and status register.
//
//   Signals:
//     read_data        pop the FIFO head (1-cycle pulse)
//     clear_status     clear the sticky error flags (1-cycle pulse)
//     bus_data         FIFO head, first-word-fall-through, valid when empty==0
//     status_register  {3'b0, parity_error, overrun, framing_error, empty, full}
//
//   Modports:
//     master  the bus side, which drives the strobes
//     slave   the receiver, which drives data and status
// ---------------------------------------------------------------------------
interface uart_receiver_if #(
    parameter int DATA_SIZE = 8
);
    logic                 read_data;
    logic                 clear_status;
    logic [DATA_SIZE-1:0] bus_data;
    logic [7:0]           status_register;

    modport master (
        output read_data,
        output clear_status,
        input  bus_data,
        input  status_register
    );

    modport slave (
        input  read_data,
        input  clear_status,
        output bus_data,
        output status_register
    );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receive stage.
//
//   The asynchronous line passes through a 2-flop synchroniser. The receiver
//   then detects the start bit and samples each bit at mid-bit using an
//   internal clocks-per-bit counter. After checking the stop bit, it pushes
//   good bytes into a receive FIFO. The FIFO head and an 8-bit status
//   register are presented on the bus interface.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, an even-parity bit is expected between the data bits and
//     the stop bit. When undefined, status_register[4] reads as 0.
//
//   Ports:
//     clk             clock; all logic runs on the rising edge
//     reset           asynchronous reset, active-high
//     serial_data_in  asynchronous UART line; idles high
//     bus             uart_receiver_if.slave (read_data, clear_status in;
//                     bus_data, status_register out)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int DATA_SIZE    = 8,
    parameter int SIZE_FIFO    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            serial_data_in,
    uart_receiver_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_SIZE + 1);
    localparam int PTR_W = $clog2(SIZE_FIFO);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic                 sync_1;
    logic                 rx_s;
    logic [CNT_W-1:0]     sample_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_SIZE-1:0] shift_reg;

    logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 pop;

    logic                 mid_bit;
    logic                 shift_en;
    logic                 push;
    logic                 overrun_set;
    logic                 framing_set;
    logic                 parity_set;

    logic                 overrun;
    logic                 framing_error;
    logic                 parity_error;

    // The two synchroniser flops reset to the idle (high) line level, so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= serial_data_in;
            rx_s   <= sync_1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign mid_bit = (sample_cnt == CNT_LAST);

    // Next-state logic.
    // START is checked half a bit in, to reject short glitches.
    // Later states sample one full bit period later, at the middle of each bit.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (sample_cnt == CNT_HALF) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (mid_bit && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid_bit) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (mid_bit) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode.
    // A pop in the same cycle as the stop sample frees a slot, so a full FIFO
    // can still accept the byte without an overrun.
    always_comb begin
        shift_en    = 1'b0;
        push        = 1'b0;
        overrun_set = 1'b0;
        framing_set = 1'b0;
        parity_set  = 1'b0;
        if (state == S_DATA && mid_bit) shift_en = 1'b1;
        if (state == S_STOP && mid_bit) begin
            if (!rx_s) begin
                framing_set = 1'b1;
            end else if (!full || pop) begin
                push = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end
`ifdef UART_RX_PARITY_EN
        if (state == S_PARITY && mid_bit && (^{shift_reg, rx_s})) parity_set = 1'b1;
`endif
    end

    // The sample counter restarts on every state change.
    // Within DATA and STOP it also wraps after each mid-bit sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (state_next != state || state == S_IDLE || mid_bit) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // The data shifts in LSB first.
    // bit_cnt returns to 0 once the last data bit has been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= {rx_s, shift_reg[DATA_SIZE-1:1]};
            bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    // Each pointer carries one extra wrap bit.
    // Equal pointers mean empty; pointers equal except for the wrap bit mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = bus.read_data && !empty;

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < SIZE_FIFO; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= shift_reg;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // The error flags are sticky. When a set and a clear_status arrive in the
    // same cycle, the set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            overrun       <= overrun_set | (overrun & ~bus.clear_status);
            framing_error <= framing_set | (framing_error & ~bus.clear_status);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= parity_set | (parity_error & ~bus.clear_status);
        end
    end
`else
    assign parity_error = parity_set;
`endif

    assign bus.bus_data        = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign bus.status_register = {3'b000, parity_error, overrun, framing_error, empty, full};

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Self-checking bench for uart_receiver. Frames are serialised onto the
//   line, and a queue model holds the bytes the FIFO should contain. A
//   monitor pops the DUT whenever it is non-empty and compares the DUT head
//   against the queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int DATA_SIZE    = 8;
    localparam int SIZE_FIFO    = 8;
    localparam int CLKS_PER_BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serialLine = 1'b1;
    logic monRead = 1'b0;
    logic manualRead = 1'b0;
    logic clearPulse = 1'b0;
    logic monitorEn = 1'b0;

    int checksTotal = 0;
    int checksPassed = 0;

    logic [7:0] expectedQ[$];
    bit modelOverrun = 0;
    bit modelFraming = 0;
    bit modelParity = 0;

    uart_receiver_if #(.DATA_SIZE(DATA_SIZE)) bus();

    assign bus.read_data    = monRead | manualRead;
    assign bus.clear_status = clearPulse;

    uart_receiver #(
        .DATA_SIZE(DATA_SIZE),
        .SIZE_FIFO(SIZE_FIFO),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .serial_data_in(serialLine),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count one comparison, and report it when it differs.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", name, actual, expected);
    endtask

    // Expected status register, derived from the model flags and the queue occupancy.
    function automatic logic [7:0] modelStatus();
        logic [7:0] s;
        s    = 8'h00;
        s[4] = (PAR_BITS != 0) ? modelParity : 1'b0;
        s[3] = modelOverrun;
        s[2] = modelFraming;
        s[1] = (expectedQ.size() == 0);
        s[0] = (expectedQ.size() == SIZE_FIFO);
        return s;
    endfunction

    // The monitor pops the DUT whenever it holds data. The pop pulse lasts one
    // cycle; the next negedge lowers it.
    always @(negedge clk) begin
        if (monRead) begin
            monRead = 1'b0;
        end else if (monitorEn && !reset && bus.status_register[1] == 1'b0) begin
            if (expectedQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL unexpectedByte: got 8'h%02h, expected no data", bus.bus_data);
            end else begin
                checkOutput("fifoHead", bus.bus_data, expectedQ.pop_front());
            end
            monRead = 1'b1;
        end
    end

    // Drive the line to a level and hold it for one full bit time.
    task automatic driveBit(input logic v);
        serialLine = v;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    // Serialise one frame.
    // The model is updated on the negedge just before the DUT's stop-bit
    // sample edge (11 posedges into the stop bit: 2 for the synchroniser,
    // plus mid-bit).
    // With readAtStop set, the head is popped on that same edge.
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit,
                                 input bit badParity, input bit readAtStop);
        logic parityBit;
        parityBit = (^data) ^ badParity;
        @(negedge clk);
        driveBit(1'b0);
        for (int i = 0; i < DATA_SIZE; i++) driveBit(data[i]);
        if (PAR_BITS != 0) driveBit(parityBit);
        serialLine = stopBit;
        for (int j = 0; j < CLKS_PER_BIT; j++) begin
            if (j == 10) begin
                if (readAtStop && expectedQ.size() != 0) begin
                    checkOutput("popAtStop", bus.bus_data, expectedQ.pop_front());
                    manualRead = 1'b1;
                end
                if (PAR_BITS != 0 && badParity) modelParity = 1;
                if (!stopBit) modelFraming = 1;
                else if (expectedQ.size() < SIZE_FIFO) expectedQ.push_back(data);
                else modelOverrun = 1;
            end
            if (j == 11) manualRead = 1'b0;
            @(negedge clk);
        end
        serialLine = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic applyClear();
        @(negedge clk);
        clearPulse = 1'b1;
        @(negedge clk);
        clearPulse = 1'b0;
        modelOverrun = 0;
        modelFraming = 0;
        modelParity  = 0;
        @(negedge clk);
    endtask

    // Let the monitor empty the FIFO, within a bounded number of cycles.
    task automatic drainFifo(input string name);
        monitorEn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (expectedQ.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        monitorEn = 1'b0;
        if (expectedQ.size() != 0) begin
            checksTotal++;
            $display("[TB] FAIL %s drain timeout: %0d bytes left, expected 0", name, expectedQ.size());
            expectedQ.delete();
        end
    endtask

    initial begin
        logic [7:0] rdata;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetStatus", bus.status_register, 8'h02);
        checkOutput("resetBusData", bus.bus_data, 8'h00);

        // A single good frame, then read it back.
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("t1StatusBeforeRead", bus.status_register, modelStatus());
        checkOutput("t1Head", bus.bus_data, 8'hA5);
        drainFifo("t1");
        checkOutput("t1StatusAfterRead", bus.status_register, modelStatus());

        // A short low glitch is rejected by the half-bit start check.
        @(negedge clk);
        serialLine = 1'b0;
        repeat (5) @(negedge clk);
        serialLine = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("t2GlitchStatus", bus.status_register, modelStatus());

        // A bad stop bit sets framing_error and drops the byte.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("t3Framing", bus.status_register, modelStatus());
        applyClear();
        checkOutput("t3Cleared", bus.status_register, modelStatus());

        // Fill to full, then overrun.
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(8'(k), 1'b1, 1'b0, 1'b0);
            if (k == 8) checkOutput("t4Full", bus.status_register, modelStatus());
            if (k == 9) checkOutput("t4Overrun", bus.status_register, modelStatus());
        end
        drainFifo("t4");
        applyClear();
        checkOutput("t4AfterDrain", bus.status_register, modelStatus());

        // A pop on the stop-sample edge frees the slot, so there is no overrun.
        for (int k = 0; k < SIZE_FIFO; k++) applyStimulus(8'h60 + 8'(k), 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b1);
        checkOutput("t5NoOverrun", bus.status_register, modelStatus());
        drainFifo("t5");
        checkOutput("t5AfterDrain", bus.status_register, modelStatus());

        // Reset in the middle of the data bits of 0xFF discards that partial frame.
        @(negedge clk);
        serialLine = 1'b0;
        repeat (CLKS_PER_BIT) @(negedge clk);
        serialLine = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        expectedQ.delete();
        modelOverrun = 0;
        modelFraming = 0;
        modelParity  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t6AfterReset", bus.status_register, modelStatus());
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
        checkOutput("t6Status", bus.status_register, modelStatus());
        drainFifo("t6");

        if (PAR_BITS != 0) begin
            applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);
            checkOutput("parityError", bus.status_register, modelStatus());
            drainFifo("parity");
            applyClear();
        end

        // Random frames with the monitor running; the stop bit is occasionally bad.
        monitorEn = 1'b1;
        for (int n = 0; n < 14; n++) begin
            rdata = 8'($urandom);
            applyStimulus(rdata, ($urandom_range(0, 5) != 0), (PAR_BITS != 0) && ($urandom_range(0, 3) == 0), 1'b0);
            checkOutput("randStatus", bus.status_register, modelStatus());
            if ($urandom_range(0, 2) == 0) begin
                applyClear();
                checkOutput("randCleared", bus.status_register, modelStatus());
            end
        end
        drainFifo("final");
        checkOutput("finalStatus", bus.status_register, modelStatus());

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
